// File: rtl/seq_abc_checker.sv
// seq_abc_checker: clocked checker for the implication a |-> ##[1:MAX_DLY] b ##1 c.
// Any number of overlapping attempts are tracked. Each attempt waits for the first b
// in its window, then needs c on the following edge.
//
// Ports:
//   clk        clock, rising-edge sampling
//   rst        synchronous active-high reset
//   a, b, c    sampled sequence terms
//   match      registered pulse, at least one attempt passed at the last edge
//   fail       registered pulse, at least one attempt failed at the last edge
//   match_cnt  saturating count of passed attempts
//   fail_cnt   saturating count of failed attempts
//   busy       combinational, at least one attempt is pending
module seq_abc_checker #(
  parameter int unsigned MAX_DLY = 3,
  parameter int unsigned CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  output logic             match,
  output logic             fail,
  output logic [CNT_W-1:0] match_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             busy
);

  localparam int unsigned CpW  = $clog2(MAX_DLY + 1);
  // One spare bit above max(CNT_W, 5) so that any overflow is visible before clamping.
  localparam int unsigned SumW = ((CNT_W > 5) ? CNT_W : 5) + 1;
  localparam logic [SumW-1:0] CntMax = (SumW'(1) << CNT_W) - SumW'(1);

  // wb_q[k] set: an attempt started k edges ago is still waiting for b.
  logic [MAX_DLY:1] wb_q, wb_d;
  // Number of attempts whose b arrived at the last edge and now need c.
  logic [CpW-1:0]   cp_q, cp_d;
  logic             match_q, fail_q;
  logic [CNT_W-1:0] match_cnt_q, match_cnt_d, fail_cnt_q, fail_cnt_d;

  logic             timeout;
  logic [SumW-1:0]  passes, fails, match_sum, fail_sum;

  always_comb begin
    wb_d    = '0;
    wb_d[1] = a;
    // Attempts age only while b is low; a b moves every waiting attempt to the c-stage.
    for (int unsigned k = 2; k <= MAX_DLY; k++) begin
      wb_d[k] = wb_q[k-1] & ~b;
    end

    cp_d = '0;
    if (b) begin
      for (int unsigned k = 1; k <= MAX_DLY; k++) begin
        cp_d = cp_d + CpW'(wb_q[k]);
      end
    end

    timeout = wb_q[MAX_DLY] & ~b;

    passes = c ? SumW'(cp_q) : '0;
    fails  = SumW'(timeout) + (c ? '0 : SumW'(cp_q));

    match_sum   = SumW'(match_cnt_q) + passes;
    fail_sum    = SumW'(fail_cnt_q) + fails;
    match_cnt_d = (match_sum > CntMax) ? '1 : match_sum[CNT_W-1:0];
    fail_cnt_d  = (fail_sum > CntMax) ? '1 : fail_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_q        <= '0;
      cp_q        <= '0;
      match_q     <= 1'b0;
      fail_q      <= 1'b0;
      match_cnt_q <= '0;
      fail_cnt_q  <= '0;
    end else begin
      wb_q        <= wb_d;
      cp_q        <= cp_d;
      match_q     <= (passes != '0);
      fail_q      <= (fails != '0);
      match_cnt_q <= match_cnt_d;
      fail_cnt_q  <= fail_cnt_d;
    end
  end

  assign match     = match_q;
  assign fail      = fail_q;
  assign match_cnt = match_cnt_q;
  assign fail_cnt  = fail_cnt_q;
  assign busy      = (|wb_q) | (cp_q != '0);

endmodule

// File: tb/tb_seq_abc_checker.sv
// Directed bench for seq_abc_checker. Two instances share the stimulus: u_dut with
// MAX_DLY=3, CNT_W=8 and u_sat with CNT_W=2 for the saturation scenario.
// Inputs change on the falling edge; outputs are checked on the falling edge after
// the rising edge under test.
module tb_seq_abc_checker;

  logic       clk;
  logic       rst;
  logic       a, b, c;
  logic       match, fail, busy;
  logic [7:0] match_cnt, fail_cnt;
  logic       s_match, s_fail, s_busy;
  logic [1:0] s_match_cnt, s_fail_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  seq_abc_checker #(.MAX_DLY(3), .CNT_W(8)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .c         (c),
    .match     (match),
    .fail      (fail),
    .match_cnt (match_cnt),
    .fail_cnt  (fail_cnt),
    .busy      (busy)
  );

  seq_abc_checker #(.MAX_DLY(3), .CNT_W(2)) u_sat (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .c         (c),
    .match     (s_match),
    .fail      (s_fail),
    .match_cnt (s_match_cnt),
    .fail_cnt  (s_fail_cnt),
    .busy      (s_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Apply inputs for one rising edge, then return at the following falling edge.
  task automatic step(input logic ia, input logic ib, input logic ic, input logic ir);
    a   = ia;
    b   = ib;
    c   = ic;
    rst = ir;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Check all main-instance outputs in one go.
  task automatic chk_all(input string tag, input logic em, input logic ef,
                         input int emc, input int efc, input logic eb);
    chk({tag, ".match"}, 32'(match), 32'(em));
    chk({tag, ".fail"}, 32'(fail), 32'(ef));
    chk({tag, ".match_cnt"}, 32'(match_cnt), 32'(emc));
    chk({tag, ".fail_cnt"}, 32'(fail_cnt), 32'(efc));
    chk({tag, ".busy"}, 32'(busy), 32'(eb));
  endtask

  initial begin
    a = 1'b0; b = 1'b0; c = 1'b0; rst = 1'b1;

    // Reset, with a high on the reset edge: no attempt may start.
    step(1, 0, 0, 1);
    chk_all("reset", 0, 0, 0, 0, 0);
    chk("reset.sat_cnt", 32'(s_match_cnt), 0);

    // Basic pass: a@1, b@2, c@3.
    step(1, 0, 0, 0);
    chk_all("pass.e1", 0, 0, 0, 0, 1);
    step(0, 1, 0, 0);
    chk_all("pass.e2", 0, 0, 0, 0, 1);
    step(0, 0, 1, 0);
    chk_all("pass.e3", 1, 0, 1, 0, 0);
    step(0, 0, 0, 0);
    chk_all("pass.idle", 0, 0, 1, 0, 0);

    // Timeout: a@1, b low at 2..4.
    step(0, 0, 0, 1);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk_all("tmo.e3", 0, 0, 0, 0, 1);
    step(0, 0, 0, 0);
    chk_all("tmo.e4", 0, 1, 0, 1, 0);
    step(0, 0, 0, 0);
    chk_all("tmo.idle", 0, 0, 0, 1, 0);

    // Missing c: a@1, b@2, c low at 3.
    step(0, 0, 0, 1);
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    chk_all("noc.e3", 0, 1, 0, 1, 0);

    // Overlap: a@1, a@2, b@3, c@4 -> one pulse, two passes.
    step(0, 0, 0, 1);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    chk_all("ovl.e3", 0, 0, 0, 0, 1);
    step(0, 0, 1, 0);
    chk_all("ovl.e4", 1, 0, 2, 0, 0);

    // Late b at the window edge: a@1, b@4, c@5.
    step(0, 0, 0, 1);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    chk_all("late.e4", 0, 0, 0, 0, 1);
    step(0, 0, 1, 0);
    chk_all("late.e5", 1, 0, 1, 0, 0);

    // a@1, a+b@2 (new attempt keeps waiting), c low @3, timeout @5.
    step(0, 0, 0, 1);
    step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    chk_all("two.e2", 0, 0, 0, 0, 1);
    step(0, 0, 0, 0);
    chk_all("two.e3", 0, 1, 0, 1, 1);
    step(0, 0, 0, 0);
    chk_all("two.e4", 0, 0, 0, 1, 1);
    step(0, 0, 0, 0);
    chk_all("two.e5", 0, 1, 0, 2, 0);

    // Same again but reset at edge 3: everything discarded.
    step(0, 0, 0, 1);
    step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    step(0, 0, 0, 1);
    chk_all("rst.e3", 0, 0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk_all("rst.e5", 0, 0, 0, 0, 0);

    // Saturation: four back-to-back passes; the 2-bit counter sticks at 3.
    step(0, 0, 0, 1);
    step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    step(1, 1, 1, 0);
    chk("sat.e3.cnt", 32'(s_match_cnt), 1);
    chk("sat.e3.match", 32'(s_match), 1);
    step(1, 1, 1, 0);
    chk("sat.e4.cnt", 32'(s_match_cnt), 2);
    step(0, 1, 1, 0);
    chk("sat.e5.cnt", 32'(s_match_cnt), 3);
    step(0, 0, 1, 0);
    chk("sat.e6.cnt", 32'(s_match_cnt), 3);
    chk("sat.e6.match", 32'(s_match), 1);
    chk("sat.e6.wide_cnt", 32'(match_cnt), 4);
    chk("sat.e6.busy", 32'(s_busy), 0);
    chk("sat.e6.fail_cnt", 32'(s_fail_cnt), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
